// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- registered execute-stage ALU with valid/ready handshakes and an
// internal NZCV flag register.
//
// Commands: MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR take one cycle. With the macro
// SEQ_ALU_MUL_EN defined, MUL (1010) is an iterative radix-2 shift-add that
// takes WIDTH cycles. Without the macro, 1010 is an illegal command and the
// multiplier hardware does not exist (busy is tied low).
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous abort of in-flight/held op (flags kept)
//   in_valid/ready  input handshake; exe_cmd, s_in, val1, val2 are the op
//   out_valid/ready output handshake; result, status {N,Z,C,V}, out_illegal
//   flags_q         architectural flag register {N,Z,C,V}
//   busy            multiply iteration in progress
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       exe_cmd,
   input  logic             s_in,
   input  logic [WIDTH-1:0] val1,
   input  logic [WIDTH-1:0] val2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       status,
   output logic             out_illegal,
   output logic [3:0]       flags_q,
   output logic             busy
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_MUL = 4'b1010;

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 8) begin : g_width_check
      $error("seq_alu: WIDTH must be at least 8");
   end
   if (2**CNT_W <= WIDTH) begin : g_cnt_w_check
      $error("seq_alu: CNT_W too narrow to count WIDTH multiply iterations");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       status_q, status_d;
   logic             illegal_q, illegal_d;
   logic [3:0]       flags_d;
   logic             in_xfer;

   // Single-cycle ALU
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic             arith_v;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, alu_illegal;
   logic [3:0]       alu_status;

   assign in_xfer = in_valid & in_ready;

`ifdef SEQ_ALU_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
   logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mul_s_q, mul_s_d;   // s_in captured at accept
   logic             start_mul;
   logic             mul_last;
   logic [WIDTH-1:0] acc_step;
   logic [3:0]       mul_status;

   assign start_mul  = (exe_cmd == CMD_MUL);
   assign mul_last   = (cnt_q == CNT_W'(WIDTH - 1));
   assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
   // MUL leaves C and V as they are in the flag register.
   assign mul_status = {acc_step[WIDTH-1], (acc_step == '0), flags_q[1:0]};
`endif

   // ---------------------------------------------------------------- ALU ---
   always_comb begin
      op_b = val2;
      cin  = 1'b0;
      case (exe_cmd)
         CMD_ADC: cin = flags_q[1];
         // Subtraction as val1 + ~val2 + 1 (SBC: + C), so carry out = NOT borrow.
         CMD_SUB: begin
            op_b = ~val2;
            cin  = 1'b1;
         end
         CMD_SBC: begin
            op_b = ~val2;
            cin  = flags_q[1];
         end
         default: ;
      endcase
      sum     = {1'b0, val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
      arith_v = (val1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);

      alu_res     = '0;
      alu_c       = flags_q[1];
      alu_v       = flags_q[0];
      alu_illegal = 1'b0;
      case (exe_cmd)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = arith_v;
         end
         CMD_AND: alu_res = val1 & val2;
         CMD_ORR: alu_res = val1 | val2;
         CMD_EOR: alu_res = val1 ^ val2;
         default: alu_illegal = 1'b1;  // MUL never takes this path when enabled
      endcase
      alu_status = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
   end

   // --------------------------------------------------------- next state ---
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (in_xfer) begin
                  state_d = ST_HOLD;
`ifdef SEQ_ALU_MUL_EN
                  if (start_mul) state_d = ST_MUL;
`endif
               end else if (state_q == ST_HOLD && out_ready) begin
                  state_d = ST_IDLE;
               end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_MUL: if (mul_last) state_d = ST_HOLD;
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ outputs ---
   always_comb begin
      in_ready  = ((state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready)) && !flush;
      out_valid = (state_q == ST_HOLD);
`ifdef SEQ_ALU_MUL_EN
      busy      = (state_q == ST_MUL);
`else
      busy      = 1'b0;
`endif
   end

   assign result      = result_q;
   assign status      = status_q;
   assign out_illegal = illegal_q;

   // ----------------------------------------------------------- datapath ---
   always_comb begin
      result_d  = result_q;
      status_d  = status_q;
      illegal_d = illegal_q;
      flags_d   = flags_q;
`ifdef SEQ_ALU_MUL_EN
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      mul_s_d   = mul_s_q;
`endif
      // in_xfer is already gated by flush; the MUL step is gated explicitly.
      if (in_xfer) begin
`ifdef SEQ_ALU_MUL_EN
         if (start_mul) begin
            mcand_d  = val1;
            mplier_d = val2;
            acc_d    = '0;
            cnt_d    = '0;
            mul_s_d  = s_in;
         end else
`endif
         begin
            result_d  = alu_res;
            status_d  = alu_status;
            illegal_d = alu_illegal;
            // Flags follow the result load, not its consumption.
            if (s_in && !alu_illegal) flags_d = alu_status;
         end
      end
`ifdef SEQ_ALU_MUL_EN
      if (!flush && state_q == ST_MUL) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (mul_last) begin
            result_d  = acc_step;
            status_d  = mul_status;
            illegal_d = 1'b0;
            if (mul_s_q) flags_d = mul_status;
         end
      end
`endif
   end

   // ---------------------------------------------------------- registers ---
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= '0;
         status_q  <= '0;
         illegal_q <= 1'b0;
         flags_q   <= '0;
`ifdef SEQ_ALU_MUL_EN
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         mul_s_q   <= 1'b0;
`endif
      end else begin
         result_q  <= result_d;
         status_q  <= status_d;
         illegal_q <= illegal_d;
         flags_q   <= flags_d;
`ifdef SEQ_ALU_MUL_EN
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         mul_s_q   <= mul_s_d;
`endif
      end
   end

endmodule
